// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchroniser, mid-bit sampling, optional odd/even parity,
// one-cycle rx_done strobe with parity and framing error flags.
module uart_rx #(
  parameter int CLOCKS_PER_BIT  = 434,
  parameter int DATA_BITS       = 8,
  parameter int CLOCK_CTR_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_serial,
  input  logic [1:0]           parity_type,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_done,
  output logic                 parity_err,
  output logic                 framing_err,
  output logic                 rx_busy
);

  localparam int IDX_WIDTH = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CLOCK_CTR_WIDTH-1:0] HALF = CLOCK_CTR_WIDTH'((CLOCKS_PER_BIT - 1) / 2);
  localparam logic [CLOCK_CTR_WIDTH-1:0] LAST = CLOCK_CTR_WIDTH'(CLOCKS_PER_BIT - 1);
  localparam logic [IDX_WIDTH-1:0]       IDX_LAST = IDX_WIDTH'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } state_t;

  state_t                     state, state_n;
  logic [CLOCK_CTR_WIDTH-1:0] cnt, cnt_n;
  logic [IDX_WIDTH-1:0]       idx, idx_n;
  logic [DATA_BITS-1:0]       shift, shift_n;
  logic [1:0]                 par_reg, par_n;
  logic                       pbit, pbit_n;
  logic [DATA_BITS-1:0]       data_n;
  logic                       done_n, perr_n, ferr_n;
  logic                       rx_meta, rx_s;

  // Synchroniser flops reset to the idle line level so reset never looks like a start bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_serial;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      idx         <= '0;
      shift       <= '0;
      par_reg     <= 2'd0;
      pbit        <= 1'b0;
      rx_data     <= '0;
      rx_done     <= 1'b0;
      parity_err  <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      idx         <= idx_n;
      shift       <= shift_n;
      par_reg     <= par_n;
      pbit        <= pbit_n;
      rx_data     <= data_n;
      rx_done     <= done_n;
      parity_err  <= perr_n;
      framing_err <= ferr_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    shift_n = shift;
    par_n   = par_reg;
    pbit_n  = pbit;
    data_n  = rx_data;
    done_n  = 1'b0;
    perr_n  = parity_err;
    ferr_n  = framing_err;

    case (state)
      IDLE: begin
        cnt_n = '0;
        idx_n = '0;
        if (!rx_s) begin
          par_n   = (parity_type == 2'd3) ? 2'd0 : parity_type;
          state_n = START;
        end
      end

      // A start bit that is high again at its midpoint is a glitch
      START: begin
        if (cnt == HALF) begin
          cnt_n   = '0;
          state_n = rx_s ? IDLE : DATA;
        end else begin
          cnt_n = cnt + CLOCK_CTR_WIDTH'(1);
        end
      end

      DATA: begin
        if (cnt == LAST) begin
          cnt_n        = '0;
          shift_n[idx] = rx_s;
          if (idx == IDX_LAST) begin
            idx_n   = '0;
            state_n = (par_reg != 2'd0) ? PARITY : STOP;
          end else begin
            idx_n = idx + IDX_WIDTH'(1);
          end
        end else begin
          cnt_n = cnt + CLOCK_CTR_WIDTH'(1);
        end
      end

      PARITY: begin
        if (cnt == LAST) begin
          cnt_n   = '0;
          pbit_n  = rx_s;
          state_n = STOP;
        end else begin
          cnt_n = cnt + CLOCK_CTR_WIDTH'(1);
        end
      end

      // par_reg 1 = odd (expected pbit ~^shift), 2 = even (expected pbit ^shift)
      STOP: begin
        if (cnt == LAST) begin
          cnt_n   = '0;
          data_n  = shift;
          done_n  = 1'b1;
          ferr_n  = ~rx_s;
          if (par_reg == 2'd0)
            perr_n = 1'b0;
          else if (par_reg == 2'd1)
            perr_n = (pbit != ~^shift);
          else
            perr_n = (pbit != ^shift);
          state_n = rx_s ? IDLE : WAIT_HIGH;
        end else begin
          cnt_n = cnt + CLOCK_CTR_WIDTH'(1);
        end
      end

      WAIT_HIGH: begin
        cnt_n = '0;
        if (rx_s) state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
        cnt_n   = '0;
        idx_n   = '0;
      end
    endcase
  end

  assign rx_busy = (state != IDLE);

endmodule
